csa_accumulator: RTL and testbench
==================================

# csa_accumulator

Parametrised, sequential successor to the combinational carry-slice benchmarks in the power sub-circuit set. It streams WIDTH-bit operands into a carry-save (sum/carry) register pair, one operand per accepted beat. On the last beat it resolves the pair with an iterative carry-propagation loop (S ^ C, (S & C) << 1). It then presents the final sum, a sticky overflow flag and a beat count on a valid/ready output port. The block sits between an operand source and a result consumer in power-profiling experiments, where per-cycle switching of the carry logic is the object of study.

## Interface
- WIDTH, 16, operand and sum width in bits (≥ 2)
- COUNT_W, 8, width of beat counter (≥ 1)

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  block accepts a beat (handshake = in_valid & in_ready)
- in_data  input  WIDTH  operand, unsigned
- in_last  input  1  marks final operand of a group; sampled with the handshake
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result (handshake = out_valid & out_ready)
- out_sum  output  WIDTH  group sum modulo 2^WIDTH
- out_overflow  output  1  true unsigned sum ≥ 2^WIDTH
- out_count  output  COUNT_W  beats in group, saturating at 2^COUNT_W−1

## Operation
- Registers: S[WIDTH], C[WIDTH], ovf, cnt[COUNT_W], state ∈ {ACCUM, RESOLVE, OUTPUT}.
- Reset (async, immediate): S=0, C=0, ovf=0, cnt=0, state=ACCUM; out_valid=0, out_sum=0, out_overflow=0, out_count=0. in_ready=0 while rst is high.
- ACCUM: in_ready=1, out_valid=0. On handshake, update the pair:
  - S ← S ^ C ^ in_data
  - M = maj(S, C, in_data); C ← M << 1, truncated to WIDTH
  - ovf ← ovf | M[WIDTH−1]
  - cnt ← cnt+1, saturating at all-ones
  - If in_last, go to RESOLVE; otherwise stay in ACCUM.
- RESOLVE: in_ready=0, out_valid=0. Each cycle:
  - If C==0, go to OUTPUT with no register update.
  - Else S ← S ^ C; P = S & C; C ← P << 1; ovf ← ovf | P[WIDTH−1]; stay in RESOLVE.
  - The loop terminates within WIDTH iterations.
- OUTPUT: out_valid=1, out_sum=S, out_overflow=ovf, out_count=cnt; in_ready=0.
  - Outputs hold stable while out_ready is low.
  - On handshake: S, C, ovf and cnt clear to 0 and state returns to ACCUM.
- Arithmetic: all unsigned. Dropped carry MSBs are the only overflow source, and the flag is exact because every term is non-negative.
- out_sum, out_overflow and out_count are driven from registers and read 0 outside OUTPUT.
- in_data and in_last are ignored when no handshake occurs.
- Reset in any state, including mid-RESOLVE or during OUTPUT backpressure, aborts the group without producing a result.

## Timing
- Accept rate: one beat per cycle in ACCUM with no bubbles.
- Last beat captured at edge E. With k carry iterations needed, out_valid rises at edge E+1+k.
  - k=0 when C==0 after the last beat.
  - Worst-case latency is WIDTH+1 cycles.
- Output handshake at edge F clears out_valid after F; in_ready is 1 from F onward.
- Minimum group period: beats + k + 2 cycles.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

## Test plan
- Reset then WIDTH=8 beats 0x03, 0x05, 0x07(last), out_ready=1 → out_sum=0x0F, out_overflow=0, out_count=3, out_valid exactly once.
- WIDTH=8 beats 0xFF, 0x01(last) → k=7, out_valid rises at E+8, out_sum=0x00, out_overflow=1, out_count=2.
- Single beat 0x00(last) → k=0, out_valid at E+1, out_sum=0, out_overflow=0, out_count=1; hold out_ready=0 for 5 cycles → outputs stable and in_ready=0 throughout; then handshake → in_ready=1 the next cycle.
- COUNT_W=2, five beats 0x01 with last on the fifth → out_count=3 (saturated), out_sum=0x05.
- Assert rst during RESOLVE of 0xFF, 0x01 → all outputs 0 immediately. After release, group 0x10(last) → out_sum=0x10 with no stale state.
- Back-to-back groups with in_valid held high and random in_valid gaps (5000 random beats checked against a golden integer sum) → every out_sum and out_overflow matches, no beat lost or duplicated.

Source files
------------

// File: rtl/csa_accumulator.sv
// csa_accumulator
// Streams unsigned operands into a carry-save (sum/carry) register pair.
// After the last beat of a group, the pair is resolved by repeating the
// carry-propagate step until the carry word is zero. The result is then
// presented on a valid/ready port. Dropped carry MSBs set a sticky
// overflow flag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ACCUM   | accepting operand beats into the carry-save pair
// RESOLVE | rippling the carry word into the sum, one step per cycle
// OUTPUT  | holding the resolved result until the consumer takes it
module csa_accumulator #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_overflow,
  output logic [COUNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   s_reg;
  logic [WIDTH-1:0]   c_reg;
  logic               ovf_reg;
  logic [COUNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0]   maj;
  logic [WIDTH-1:0]   prop;
  logic               in_fire;

  // Carry-generate terms: 3:2 majority for a new beat, 2:2 AND while resolving
  always_comb begin
    maj  = (s_reg & c_reg) | (s_reg & in_data) | (c_reg & in_data);
    prop = s_reg & c_reg;
  end

  // in_ready depends only on state and reset, never on in_valid
  assign in_ready = (state == ACCUM) && !rst;
  assign in_fire  = in_valid && in_ready;

  // Datapath, sequencing and registered result port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ACCUM;
      s_reg        <= '0;
      c_reg        <= '0;
      ovf_reg      <= 1'b0;
      cnt_reg      <= '0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
      out_count    <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_fire) begin
            s_reg   <= s_reg ^ c_reg ^ in_data;
            c_reg   <= {maj[WIDTH-2:0], 1'b0};
            ovf_reg <= ovf_reg | maj[WIDTH-1];
            if (cnt_reg != {COUNT_W{1'b1}}) begin
              cnt_reg <= cnt_reg + COUNT_W'(1);
            end
            if (in_last) begin
              state <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          if (c_reg == '0) begin
            // Pair is fully resolved; latch the result into the port registers
            state        <= OUTPUT;
            out_valid    <= 1'b1;
            out_sum      <= s_reg;
            out_overflow <= ovf_reg;
            out_count    <= cnt_reg;
          end else begin
            s_reg   <= s_reg ^ c_reg;
            c_reg   <= {prop[WIDTH-2:0], 1'b0};
            ovf_reg <= ovf_reg | prop[WIDTH-1];
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state        <= ACCUM;
            s_reg        <= '0;
            c_reg        <= '0;
            ovf_reg      <= 1'b0;
            cnt_reg      <= '0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
            out_count    <= '0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed and random bench for csa_accumulator (WIDTH=8, COUNT_W=2).
// Expected results are pushed to a queue when a group's last beat is driven.
// A negedge monitor pops and compares them on each output handshake.
module tb_csa_accumulator;
  localparam int WIDTH   = 8;
  localparam int COUNT_W = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [WIDTH-1:0]   out_sum;
  logic               out_overflow;
  logic [COUNT_W-1:0] out_count;

  typedef struct packed {
    logic [WIDTH-1:0]   sum;
    logic               ovf;
    logic [COUNT_W-1:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests   = 0;
  int          fails   = 0;
  int          results = 0;
  int          pushed  = 0;
  int unsigned acc     = 0;
  int          beats   = 0;

  csa_accumulator #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.sum = acc[WIDTH-1:0];
    e.ovf = (acc >= 256);
    e.cnt = (beats > 3) ? 2'd3 : COUNT_W'(beats);
    sb.push_back(e);
    pushed++;
    acc   = 0;
    beats = 0;
  endtask

  // Offer one beat and return #1 after the edge that accepted it
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    acc   += d;
    beats++;
    if (last) push_expected();
    @(negedge clk);
    while (!in_ready) begin
      t++;
      if (t > 100) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Count negedges after the last-beat edge until out_valid is seen
  task automatic wait_valid(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 50) begin
        check("out_valid_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one comparison set per output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      results++;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out_sum", 32'(out_sum), 32'(mon_e.sum));
        check("out_overflow", 32'(out_overflow), 32'(mon_e.ovf));
        check("out_count", 32'(out_count), 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    int n;
    int r0;
    int total;
    int glen;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Group 1: 3+5+7 = 0x0F, exactly one result
    out_ready = 1'b1;
    r0 = results;
    send(8'h03, 1'b0);
    send(8'h05, 1'b0);
    send(8'h07, 1'b1);
    wait_valid(n);
    idle(3);
    check("g1_results_once", 32'(results - r0), 32'd1);
    check("g1_valid_cleared", 32'(out_valid), 32'd0);
    check("g1_sum_cleared", 32'(out_sum), 32'd0);

    // Group 2: 0xFF + 0x01 needs 7 carry iterations, so latency is 8
    send(8'hFF, 1'b0);
    send(8'h01, 1'b1);
    wait_valid(n);
    check("g2_latency", 32'(n), 32'd8);
    idle(2);

    // Group 3: single zero beat, k=0, then backpressure
    out_ready = 1'b0;
    send(8'h00, 1'b1);
    wait_valid(n);
    check("g3_latency", 32'(n), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("g3_hold_valid", 32'(out_valid), 32'd1);
      check("g3_hold_sum", 32'(out_sum), 32'd0);
      check("g3_hold_count", 32'(out_count), 32'd1);
      check("g3_hold_ovf", 32'(out_overflow), 32'd0);
      check("g3_hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("g3_in_ready_after_hs", 32'(in_ready), 32'd1);
    check("g3_valid_after_hs", 32'(out_valid), 32'd0);

    // Group 4: five beats of 1, count saturates at 3
    for (int i = 0; i < 5; i++) send(8'h01, (i == 4));
    wait_valid(n);
    idle(2);

    // Group 5: reset mid-RESOLVE aborts the group
    send(8'hFF, 1'b0);
    send(8'h01, 1'b1);
    idle(1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_sum", 32'(out_sum), 32'd0);
    check("abort_out_ovf", 32'(out_overflow), 32'd0);
    check("abort_out_count", 32'(out_count), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    void'(sb.pop_back());
    pushed--;
    idle(2);
    rst = 1'b0;
    send(8'h10, 1'b1);
    wait_valid(n);
    check("post_abort_latency", 32'(n), 32'd1);
    idle(2);

    // Random back-to-back groups with occasional input gaps
    total = 0;
    while (total < 5000) begin
      glen = $urandom_range(1, 12);
      if (total + glen > 5000) glen = 5000 - total;
      for (int i = 0; i < glen; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send(8'($urandom_range(0, 255)), (i == glen - 1));
      end
      total += glen;
    end
    idle(40);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("result_count", 32'(results), 32'(pushed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
